// File: rtl/softermax_pkg.sv
// Shared types, default widths and helpers for the softermax unnormalised stage.
// Holds the FSM state encoding and the integer-ceiling used for max tracking.
package softermax_pkg;

    localparam int DEF_BW       = 8;
    localparam int DEF_IN_FW    = 2;
    localparam int DEF_ACCUM_BW = 16;
    localparam int DEF_ACCUM_FW = 6;
    localparam int DEF_VEC_SIZE = 10;

    localparam int POW2_LUT_DEPTH = 2**DEF_IN_FW;

    typedef logic [DEF_ACCUM_BW-1:0] accum_t;

    typedef enum logic {
        COLLECT,
        DONE
    } state_t;

    localparam logic signed [DEF_BW:0] CEIL_BIAS = (DEF_BW+1)'(POW2_LUT_DEPTH - 1);

    // Ceiling of a fixed-point logit to an integer; one extra bit keeps x+bias from wrapping.
    function automatic logic signed [DEF_BW-DEF_IN_FW:0] ceil_int(input logic signed [DEF_BW-1:0] x);
        logic signed [DEF_BW:0] biased;
        biased = (DEF_BW+1)'(x) + CEIL_BIAS;
        return (DEF_BW-DEF_IN_FW+1)'(biased >>> DEF_IN_FW);
    endfunction

endpackage

// File: rtl/softermax_unnorm_pow2_lut.sv
// Fractional power-of-two table: value = round(2^(frac/2^IN_FW) * 2^ACCUM_FW).
// Purely combinational, indexed by the fractional bits of the exponent.
module pow2_lut
    import softermax_pkg::*;
#(
    parameter int IN_FW    = DEF_IN_FW,
    parameter int ACCUM_FW = DEF_ACCUM_FW
) (
    input  logic [IN_FW-1:0] frac_i,
    output accum_t           value_o
);

    always_comb begin
        value_o = '0;
        case (frac_i)
            IN_FW'(0): value_o = accum_t'(1) << ACCUM_FW;
            IN_FW'(1): value_o = accum_t'(76);
            IN_FW'(2): value_o = accum_t'(91);
            IN_FW'(3): value_o = accum_t'(108);
            default:   value_o = '0;
        endcase
    end

endmodule

// File: rtl/softermax_unnorm.sv
// Streams logits, tracks the running integer max and builds base-2 numerators plus
// their denominator, rescaling the stored values online whenever the max grows.
module softermax_unnorm
    import softermax_pkg::*;
#(
    parameter int BW       = DEF_BW,
    parameter int IN_FW    = DEF_IN_FW,
    parameter int ACCUM_BW = DEF_ACCUM_BW,
    parameter int ACCUM_FW = DEF_ACCUM_FW,
    parameter int VEC_SIZE = DEF_VEC_SIZE
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic signed [BW-1:0]               in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [VEC_SIZE-1:0][ACCUM_BW-1:0]  vec_out,
    output logic [ACCUM_BW-1:0]                denom_out,
    output logic signed [BW-1:0]               max_out
);

    localparam int CNT_W = $clog2(VEC_SIZE);
    localparam int CW    = BW - IN_FW + 1;
    localparam int EW    = BW + 2;

    state_t                            state_q, state_d;
    logic [CNT_W-1:0]                  count_q, count_d;
    logic signed [CW-1:0]              max_q, max_d;
    logic [ACCUM_BW-1:0]               denom_q, denom_d;
    logic [VEC_SIZE-1:0][ACCUM_BW-1:0] buf_q, buf_d;

    logic                  accept;
    logic                  release_vec;
    logic                  first;
    logic signed [CW-1:0]  ceil_x;
    logic signed [CW-1:0]  max_new;
    logic [CW:0]           diff;
    logic [EW-1:0]         d_amt;
    logic [EW-1:0]         neg_k;
    logic signed [EW-1:0]  e_val;
    logic signed [EW-1:0]  k_val;
    logic [ACCUM_BW-1:0]   lut_val;
    logic [ACCUM_BW-1:0]   term;
    logic [ACCUM_BW-1:0]   denom_shifted;
    logic [ACCUM_BW:0]     denom_sum;

    // Shifting by the full word width or more must flush to zero rather than wrap.
    function automatic logic [ACCUM_BW-1:0] shr_sat(input logic [ACCUM_BW-1:0] v,
                                                    input logic [EW-1:0]       amt);
        return (amt >= EW'(ACCUM_BW)) ? '0 : (v >> amt);
    endfunction

    pow2_lut #(
        .IN_FW    (IN_FW),
        .ACCUM_FW (ACCUM_FW)
    ) u_pow2_lut (
        .frac_i  (e_val[IN_FW-1:0]),
        .value_o (lut_val)
    );

    always_comb begin
        accept        = (state_q == COLLECT) && in_valid;
        release_vec   = (state_q == DONE) && out_ready;
        first         = (count_q == '0);
        ceil_x        = ceil_int(in_data);
        max_new       = (first || (ceil_x > max_q)) ? ceil_x : max_q;
        diff          = (CW+1)'(max_new) - (CW+1)'(max_q);
        d_amt         = first ? '0 : EW'(diff);
        e_val         = EW'(in_data) - (EW'(max_new) <<< IN_FW);
        k_val         = e_val >>> IN_FW;
        neg_k         = -k_val;
        term          = shr_sat(lut_val, neg_k);
        denom_shifted = shr_sat(denom_q, d_amt);
        denom_sum     = {1'b0, denom_shifted} + {1'b0, term};
    end

    // Next-state and outputs; a release clears the whole vector on the same edge.
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        max_d     = max_q;
        denom_d   = denom_q;
        buf_d     = buf_q;
        in_ready  = (state_q == COLLECT);
        out_valid = (state_q == DONE);

        if (accept) begin
            max_d   = max_new;
            denom_d = denom_sum[ACCUM_BW] ? '1 : denom_sum[ACCUM_BW-1:0];
            for (int i = 0; i < VEC_SIZE; i++) begin
                buf_d[i] = (count_q == CNT_W'(i)) ? term : shr_sat(buf_q[i], d_amt);
            end
            if (count_q == CNT_W'(VEC_SIZE-1)) begin
                state_d = DONE;
            end else begin
                count_d = count_q + 1'b1;
            end
        end else if (release_vec) begin
            state_d = COLLECT;
            count_d = '0;
            max_d   = '0;
            denom_d = '0;
            buf_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            count_q <= '0;
            max_q   <= '0;
            denom_q <= '0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            max_q   <= max_d;
            denom_q <= denom_d;
            buf_q   <= buf_d;
        end
    end

    assign vec_out   = buf_q;
    assign denom_out = denom_q;
    assign max_out   = BW'(max_q);

endmodule

// File: tb/tb_softermax_unnorm.sv
// Self-checking bench for softermax_unnorm: random and directed vectors checked every
// cycle against a behavioural model rebuilt from the raw accepted logits.
module tb_softermax_unnorm;

    localparam int VS = 4;

    logic                  clk       = 1'b0;
    logic                  rst_n     = 1'b0;
    logic                  in_valid  = 1'b0;
    logic                  out_ready = 1'b0;
    logic signed [7:0]     in_data   = '0;
    logic                  in_ready;
    logic                  out_valid;
    logic [VS-1:0][15:0]   vec_out;
    logic [15:0]           denom_out;
    logic signed [7:0]     max_out;

    int checks = 0;
    int errors = 0;

    int lut [4] = '{64, 76, 91, 108};
    int mX [VS];
    int mN       = 0;
    bit mCollect = 1'b1;
    int expVec [VS];
    int expDen;
    int expMax;

    always #5 clk = ~clk;

    softermax_unnorm #(
        .BW       (8),
        .IN_FW    (2),
        .ACCUM_BW (16),
        .ACCUM_FW (6),
        .VEC_SIZE (VS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .vec_out   (vec_out),
        .denom_out (denom_out),
        .max_out   (max_out)
    );

    task automatic checkOutput(input string nm, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int ceil4(input int x);
        int t;
        t = x + 3;
        return (t >= 0) ? (t / 4) : -((-t + 3) / 4);
    endfunction

    function automatic int shiftDown(input int v, input int s);
        return (s >= 16) ? 0 : (v >> s);
    endfunction

    // 2^((x - 4m)/4) in Q.6, with the fractional part looked up and the integer part as a shift.
    function automatic int termOf(input int x, input int m);
        int e, k, f;
        e = x - 4 * m;
        k = -((-e + 3) / 4);
        f = e - 4 * k;
        return shiftDown(lut[f], -k);
    endfunction

    task automatic computeExpected();
        int m, c, mi, dd, den;
        int arrTerm [VS];
        int arrMax [VS];
        m   = 0;
        den = 0;
        for (int i = 0; i < VS; i++) expVec[i] = 0;
        for (int i = 0; i < mN; i++) begin
            c  = ceil4(mX[i]);
            mi = (i == 0 || c > m) ? c : m;
            dd = (i == 0) ? 0 : mi - m;
            arrTerm[i] = termOf(mX[i], mi);
            arrMax[i]  = mi;
            den = shiftDown(den, dd) + arrTerm[i];
            if (den > 65535) den = 65535;
            m = mi;
        end
        for (int i = 0; i < mN; i++) expVec[i] = shiftDown(arrTerm[i], m - arrMax[i]);
        expDen = den;
        expMax = (mN == 0) ? 0 : m;
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mCollect <= 1'b1;
            mN       <= 0;
        end else if (mCollect) begin
            if (in_valid) begin
                mX[mN] <= int'(in_data);
                mN     <= mN + 1;
                if (mN == VS - 1) mCollect <= 1'b0;
            end
        end else if (out_ready) begin
            mCollect <= 1'b1;
            mN       <= 0;
        end
    end

    always @(negedge clk) begin
        computeExpected();
        checkOutput("in_ready", in_ready, mCollect);
        checkOutput("out_valid", out_valid, !mCollect);
        checkOutput("denom_out", denom_out, expDen);
        checkOutput("max_out", max_out, expMax);
        for (int i = 0; i < VS; i++) begin
            checkOutput($sformatf("vec_out[%0d]", i), vec_out[i], expVec[i]);
        end
    end

    task automatic applyStimulus(input int x, input int gap);
        int guard;
        guard = 0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = 8'(x);
        while (!in_ready && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) checkOutput("in_ready_timeout", 0, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic sendVector(input int xs [VS], input bit gaps);
        for (int i = 0; i < VS; i++) begin
            applyStimulus(xs[i], gaps ? int'($urandom_range(0, 2)) : 0);
        end
    endtask

    task automatic waitOutValid();
        int guard;
        guard = 0;
        while (!out_valid && guard < 50) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (guard >= 50) checkOutput("out_valid_timeout", 0, 1);
    endtask

    task automatic releaseVector(input int hold);
        repeat (hold) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        int v [VS];

        #2;
        checkOutput("reset_in_ready", in_ready, 1);
        checkOutput("reset_out_valid", out_valid, 0);
        checkOutput("reset_denom", denom_out, 0);
        checkOutput("reset_max", max_out, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        v = '{0, 0, 0, 0};
        sendVector(v, 1'b0);
        checkOutput("latency_out_valid", out_valid, 1);
        checkOutput("zeros_vec0", vec_out[0], 64);
        checkOutput("zeros_vec3", vec_out[3], 64);
        checkOutput("zeros_denom", denom_out, 256);
        checkOutput("zeros_max", max_out, 0);
        releaseVector(0);

        v = '{0, 4, 0, 0};
        sendVector(v, 1'b0);
        waitOutValid();
        checkOutput("grow_vec0", vec_out[0], 32);
        checkOutput("grow_vec1", vec_out[1], 64);
        checkOutput("grow_vec2", vec_out[2], 32);
        checkOutput("grow_denom", denom_out, 160);
        checkOutput("grow_max", max_out, 1);
        releaseVector(1);

        v = '{1, 0, 0, 0};
        sendVector(v, 1'b1);
        waitOutValid();
        checkOutput("frac_vec0", vec_out[0], 38);
        checkOutput("frac_vec1", vec_out[1], 32);
        checkOutput("frac_denom", denom_out, 134);
        checkOutput("frac_max", max_out, 1);
        releaseVector(0);

        v = '{-128, 127, 0, 0};
        sendVector(v, 1'b0);
        waitOutValid();
        checkOutput("bigshift_vec0", vec_out[0], 0);
        checkOutput("bigshift_vec1", vec_out[1], 54);
        checkOutput("bigshift_denom", denom_out, 54);
        checkOutput("bigshift_max", max_out, 32);
        releaseVector(5);
        checkOutput("after_release_in_ready", in_ready, 1);
        checkOutput("after_release_denom", denom_out, 0);

        applyStimulus(0, 0);
        applyStimulus(0, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", out_valid, 0);
        checkOutput("midreset_denom", denom_out, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        v = '{8, -3, 20, 5};
        sendVector(v, 1'b0);
        waitOutValid();
        releaseVector(2);

        for (int n = 0; n < 20; n++) begin
            for (int i = 0; i < VS; i++) begin
                v[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255)) - 128
                                                   : int'($urandom_range(0, 24)) - 12;
            end
            sendVector(v, 1'($urandom_range(0, 1)));
            waitOutValid();
            releaseVector(int'($urandom_range(0, 3)));
        end

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
